// File: rtl/vid_axis_pkg.sv
`default_nettype none
// ============================================================================
// vid_axis_pkg : shared beat layout for the video-to-AXI4-Stream bridge
// Revision 1.0 : initial release
// ============================================================================
package vid_axis_pkg;

  localparam int DATA_BITS = 8;
  localparam int BEAT_W    = DATA_BITS + 2;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 last;
    logic                 user;
  } axis_beat_t;

endpackage
`default_nettype wire

// File: rtl/v2a_sync_fifo.sv
`default_nettype none
// ============================================================================
// v2a_sync_fifo : single-clock first-word-fall-through FIFO
// Revision 1.0 : initial release
// ============================================================================
module v2a_sync_fifo #(
  parameter int WIDTH     = 10,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     pop_data,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   count
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == (ADDR_BITS+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (ADDR_BITS+1)'(do_push) - (ADDR_BITS+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/vid_to_axis_stream.sv
`default_nettype none
// ============================================================================
// vid_to_axis_stream : DVP-style video (vsync/href/data) to AXI4-Stream video
//   Optional build macro V2A_OVERFLOW_STICKY_EN makes overflow sticky.
// Revision 1.0 : initial release
// ============================================================================
module vid_to_axis_stream #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 5
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 vid_ce,
  input  logic                 vid_vsync,
  input  logic                 vid_active_video,
  input  logic [DATA_BITS-1:0] vid_data,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 overflow
);

  import vid_axis_pkg::*;

  logic                 hold_valid;
  logic                 hold_sof;
  logic [DATA_BITS-1:0] hold_data;
  logic                 sof_pending;

  axis_beat_t           push_beat;
  axis_beat_t           pop_beat;
  logic                 push_req;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 drop;
  logic [ADDR_BITS:0]   count;

  // The held pixel leaves on the next sample; an inactive sample marks it end-of-line.
  assign push_req  = vid_ce && hold_valid;
  assign push_beat = '{data: hold_data, last: !vid_active_video, user: hold_sof};
  assign pop       = !empty && m_axis_tready;
  assign drop      = push_req && full && !pop;

  always_ff @(posedge aclk) begin
    if (areset) begin
      hold_valid  <= 1'b0;
      hold_sof    <= 1'b0;
      hold_data   <= '0;
      sof_pending <= 1'b0;
    end else if (vid_ce) begin
      if (vid_active_video) begin
        hold_valid  <= 1'b1;
        hold_data   <= vid_data;
        hold_sof    <= sof_pending || vid_vsync;
        sof_pending <= 1'b0;
      end else begin
        hold_valid  <= 1'b0;
        if (vid_vsync) sof_pending <= 1'b1;
      end
    end
  end

  v2a_sync_fifo #(
    .WIDTH     (BEAT_W),
    .ADDR_BITS (ADDR_BITS)
  ) u_fifo (
    .clk       (aclk),
    .rst       (areset),
    .push      (push_req),
    .push_data (push_beat),
    .pop       (pop),
    .pop_data  (pop_beat),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Payload is forced low while empty so unwritten RAM never reaches the port.
  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = empty ? '0   : pop_beat.data;
  assign m_axis_tlast  = empty ? 1'b0 : pop_beat.last;
  assign m_axis_tuser  = empty ? 1'b0 : pop_beat.user;

`ifdef V2A_OVERFLOW_STICKY_EN
  logic ovf_sticky;

  always_ff @(posedge aclk) begin
    if (areset)    ovf_sticky <= 1'b0;
    else if (drop) ovf_sticky <= 1'b1;
  end

  assign overflow = !areset && (ovf_sticky || drop);
`else
  assign overflow = !areset && drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vid_to_axis_stream.sv
`default_nettype none
// ============================================================================
// tb_vid_to_axis_stream : randomized bench with a queue-based reference model
// Revision 1.0 : initial release
// ============================================================================
module tb_vid_to_axis_stream;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          vid_ce = 1'b0;
  logic          vid_vsync = 1'b0;
  logic          vid_active_video = 1'b0;
  logic [DW-1:0] vid_data = '0;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          overflow;

  vid_to_axis_stream #(.DATA_BITS(DW), .ADDR_BITS(AW)) dut (
    .aclk             (aclk),
    .areset           (areset),
    .vid_ce           (vid_ce),
    .vid_vsync        (vid_vsync),
    .vid_active_video (vid_active_video),
    .vid_data         (vid_data),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .overflow         (overflow)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  // Model: a pixel becomes a beat when the next sample arrives; the queue is the FIFO.
  beat_t         mq[$];
  beat_t         log_q[$];
  logic          mh_valid = 1'b0;
  logic          mh_sof = 1'b0;
  logic [DW-1:0] mh_data = '0;
  logic          m_sofp = 1'b0;
  logic          m_sticky = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            ovf_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_drop();
    bit pop;
    pop = (mq.size() != 0) && m_axis_tready;
    return vid_ce && mh_valid && (mq.size() == DEPTH) && !pop;
  endfunction

  always @(posedge aclk) begin
    if (areset) begin
      mq.delete();
      mh_valid = 1'b0;
      mh_sof   = 1'b0;
      mh_data  = '0;
      m_sofp   = 1'b0;
      m_sticky = 1'b0;
    end else begin
      bit    pop;
      bit    drop;
      beat_t b;
      pop  = (mq.size() != 0) && m_axis_tready;
      drop = m_drop();
      if (pop) void'(mq.pop_front());
      if (vid_ce && mh_valid && !drop) begin
        b.data = mh_data;
        b.last = !vid_active_video;
        b.user = mh_sof;
        mq.push_back(b);
      end
      if (drop) m_sticky = 1'b1;
      if (vid_ce) begin
        if (vid_active_video) begin
          mh_valid = 1'b1;
          mh_data  = vid_data;
          mh_sof   = m_sofp || vid_vsync;
          m_sofp   = 1'b0;
        end else begin
          mh_valid = 1'b0;
          m_sofp   = m_sofp || vid_vsync;
        end
      end
    end
  end

  always @(negedge aclk) begin
    if (!areset) begin
      bit    exp_ovf;
      beat_t b;
`ifdef V2A_OVERFLOW_STICKY_EN
      exp_ovf = m_drop() || m_sticky;
`else
      exp_ovf = m_drop();
`endif
      chk("tvalid", m_axis_tvalid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("tdata", m_axis_tdata, mq[0].data);
        chk("tlast", m_axis_tlast, mq[0].last);
        chk("tuser", m_axis_tuser, mq[0].user);
      end
      chk("overflow", overflow, exp_ovf);
      if (overflow) ovf_cycles++;
      if (m_axis_tvalid && m_axis_tready) begin
        b = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
        log_q.push_back(b);
      end
    end
  end

  task automatic step(input bit ce, input bit vs, input bit av, input logic [DW-1:0] d);
    vid_ce = ce;
    vid_vsync = vs;
    vid_active_video = av;
    vid_data = d;
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    areset = 1'b0;
    log_q.delete();
    ovf_cycles = 0;
  endtask

  task automatic line(input logic [DW-1:0] start, input int n, input bit vs_first);
    if (vs_first) step(1, 1, 0, 8'h00);
    for (int i = 0; i < n; i++) step(1, 0, 1, start + DW'(i));
    step(1, 0, 0, 8'h00);
  endtask

  task automatic drain();
    int k;
    k = 0;
    m_axis_tready = 1'b1;
    while (m_axis_tvalid && k < 300) begin
      step(0, 0, 0, 8'h00);
      k++;
    end
    step(0, 0, 0, 8'h00);
    chk("drain_timeout", m_axis_tvalid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nu;
    int nl;
    int bad;
    bit act;
    bit rdy_bias;

    @(posedge aclk);
    #1;

    // Reset state
    do_reset();
    #1;
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tdata", m_axis_tdata, 8'h00);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_tuser", m_axis_tuser, 1'b0);
    chk("rst_overflow", overflow, 1'b0);

    // 1: basic 4-pixel line
    m_axis_tready = 1'b1;
    line(8'h10, 4, 1);
    chk("t1_latency_tdata", m_axis_tdata, 8'h13);
    chk("t1_latency_tlast", m_axis_tlast, 1'b1);
    drain();
    chk("t1_beats", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      chk("t1_data", log_q[i].data, 8'h10 + 8'(i));
      chk("t1_user", log_q[i].user, i == 0);
      chk("t1_last", log_q[i].last, i == 3);
    end
    chk("t1_no_overflow", ovf_cycles, 0);

    // 2: two 960-pixel lines in one frame
    do_reset();
    m_axis_tready = 1'b1;
    line(8'h00, 960, 1);
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    line(8'h00, 960, 0);
    drain();
    chk("t2_beats", log_q.size(), 1920);
    nu = 0; nl = 0; bad = 0;
    foreach (log_q[i]) begin
      if (log_q[i].user) nu++;
      if (log_q[i].last) nl++;
      if (log_q[i].data != 8'(i % 960)) bad++;
    end
    chk("t2_user_count", nu, 1);
    chk("t2_last_count", nl, 2);
    chk("t2_data_errors", bad, 0);
    if (log_q.size() == 1920) begin
      chk("t2_first_user", log_q[0].user, 1'b1);
      chk("t2_last_959", log_q[959].last, 1'b1);
      chk("t2_last_1919", log_q[1919].last, 1'b1);
    end

    // 3: ce toggling with junk on disabled samples
    do_reset();
    m_axis_tready = 1'b1;
    step(0, 1, 1, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 8'h20 + 8'(i));
      step(0, 1, $urandom_range(0, 1), 8'($urandom));
    end
    step(1, 0, 0, 8'h00);
    drain();
    chk("t3_beats", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      chk("t3_data", log_q[i].data, 8'h20 + 8'(i));
      chk("t3_user", log_q[i].user, 1'b0);
      chk("t3_last", log_q[i].last, i == 3);
    end

    // 4: back-pressure over a 40-pixel line
    do_reset();
    m_axis_tready = 1'b0;
    line(8'h40, 40, 1);
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    chk("t4_tvalid_held", m_axis_tvalid, 1'b1);
    chk("t4_tdata_stable", m_axis_tdata, 8'h40);
    chk("t4_tuser_head", m_axis_tuser, 1'b1);
`ifdef V2A_OVERFLOW_STICKY_EN
    chk("t4_sticky", overflow, 1'b1);
`else
    chk("t4_drop_pulses", ovf_cycles, 8);
`endif
    drain();
    chk("t4_beats", log_q.size(), 32);
    if (log_q.size() == 32) begin
      chk("t4_tail_data", log_q[31].data, 8'h5F);
      chk("t4_tail_last", log_q[31].last, 1'b0);
    end
`ifdef V2A_OVERFLOW_STICKY_EN
    chk("t4_sticky_after", overflow, 1'b1);
`endif

    // 5: full FIFO with simultaneous push and pop
    do_reset();
    m_axis_tready = 1'b0;
    step(1, 1, 0, 8'h00);
    for (int i = 0; i < 33; i++) step(1, 0, 1, 8'(i));
    chk("t5_full_no_drop", ovf_cycles, 0);
    m_axis_tready = 1'b1;
    for (int i = 33; i < 43; i++) step(1, 0, 1, 8'(i));
    step(1, 0, 0, 8'h00);
    chk("t5_push_pop_no_drop", ovf_cycles, 0);
    drain();
    chk("t5_beats", log_q.size(), 43);
    bad = 0;
    foreach (log_q[i]) if (log_q[i].data != 8'(i) || log_q[i].last != (i == 42)) bad++;
    chk("t5_sequence_errors", bad, 0);

    // 6: reset mid-line with 10 beats queued
    do_reset();
    m_axis_tready = 1'b0;
    step(1, 1, 0, 8'h00);
    for (int i = 0; i < 11; i++) step(1, 0, 1, 8'h50 + 8'(i));
    chk("t6_queued", m_axis_tvalid, 1'b1);
    areset = 1'b1;
    step(1, 0, 1, 8'h99);
    areset = 1'b0;
    vid_ce = 1'b0;
    #1;
    chk("t6_tvalid_after_rst", m_axis_tvalid, 1'b0);
    chk("t6_overflow_after_rst", overflow, 1'b0);
    log_q.delete();
    m_axis_tready = 1'b1;
    line(8'h70, 3, 0);
    drain();
    chk("t6_beats", log_q.size(), 3);
    nu = 0;
    foreach (log_q[i]) if (log_q[i].user) nu++;
    chk("t6_no_user", nu, 0);
    if (log_q.size() == 3) chk("t6_last", log_q[2].last, 1'b1);

    // Randomized traffic, checked every cycle by the model
    do_reset();
    act = 1'b0;
    rdy_bias = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) rdy_bias = ~rdy_bias;
      if ($urandom_range(0, 19) == 0) act = ~act;
      m_axis_tready = rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, act, 8'($urandom));
    end
    step(1, 0, 0, 8'h00);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
